// File: rtl/bp_pkg.sv
// Shared types, constants and the saturating 2-bit counter update
// used by the fetch-side branch predictor.
package bp_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_SNT = 2'b00;
  localparam bht_ctr_t CTR_WNT = 2'b01;
  localparam bht_ctr_t CTR_WT  = 2'b10;
  localparam bht_ctr_t CTR_ST  = 2'b11;

  localparam int unsigned PC_INC = 4;

  // Move one step toward the resolved direction, sticking at either end.
  function automatic bht_ctr_t sat_update(bht_ctr_t ctr, logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : bht_ctr_t'(ctr + 2'd1);
    end
    return (ctr == CTR_SNT) ? CTR_SNT : bht_ctr_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Decode/execute branch bus between the core pipeline (master) and the
// predictor (slave).
interface branch_predict_ctrl_if #(
  parameter int DW = 32
);
  logic          id_is_branch;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] id_target;
  logic          id_pred_taken;
  logic          ex_is_branch;
  logic          ex_is_jalr;
  logic [DW-1:0] ex_pc;
  logic          ex_pred_taken;
  logic          ex_taken;
  logic [DW-1:0] ex_target;

  modport master (
    output id_is_branch, id_pc, id_target,
    output ex_is_branch, ex_is_jalr, ex_pc, ex_pred_taken, ex_taken, ex_target,
    input  id_pred_taken
  );

  modport slave (
    input  id_is_branch, id_pc, id_target,
    input  ex_is_branch, ex_is_jalr, ex_pc, ex_pred_taken, ex_taken, ex_target,
    output id_pred_taken
  );
endinterface

// File: rtl/branch_predict_ctrl_bht.sv
// Bimodal history table: array of 2-bit saturating counters with one
// combinational read port (decode) and one training port (execute).
// The read port returns the stored value, so a same-cycle write to the
// same entry is only visible from the next cycle on.
module bht_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_ctr_t         rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  bht_ctr_t ctr_q [ENTRIES];

  assign rd_ctr_o = ctr_q[rd_idx_i];

  // Train the addressed counter; reset returns every entry to weakly not-taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= sat_update(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch PC sequencer with bimodal branch prediction. Decode-stage branches
// that hit a taken counter redirect fetch early; execute-stage outcomes
// train the table and repair mispredicts (and JALR) with a full flush.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int          DW          = 32,
  parameter int          BHT_ENTRIES = 16,
  parameter logic [DW-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          stall_i,
  output logic [DW-1:0] pc_o,
  output logic          flush_if_id_o,
  output logic          flush_id_ex_o,
  output logic [31:0]   branch_cnt_o,
  output logic [31:0]   mispredict_cnt_o,
  branch_predict_ctrl_if.slave bp_if
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [DW-1:0]    pc_q, pc_d;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;
  logic             flush_if_id_d, flush_id_ex_d;
  logic [IDX_W-1:0] id_idx, ex_idx;
  bht_ctr_t         id_ctr;
  logic             id_pred_taken;
  logic             ex_mispredict, ex_redirect, id_redirect;

  assign id_idx = bp_if.id_pc[IDX_W+1:2];
  assign ex_idx = bp_if.ex_pc[IDX_W+1:2];

  bht_table #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_idx_i   (id_idx),
    .rd_ctr_o   (id_ctr),
    .wr_en_i    (bp_if.ex_is_branch),
    .wr_idx_i   (ex_idx),
    .wr_taken_i (bp_if.ex_taken)
  );

  assign id_pred_taken       = bp_if.id_is_branch & id_ctr[1];
  assign bp_if.id_pred_taken = id_pred_taken;

  assign ex_mispredict = bp_if.ex_is_branch & (bp_if.ex_pred_taken != bp_if.ex_taken);
  assign ex_redirect   = ex_mispredict | bp_if.ex_is_jalr;
  // A stalled decode branch must not redirect; it predicts again once released.
  assign id_redirect   = id_pred_taken & ~stall_i;

  // Next-PC select: execute repair beats decode prediction beats stall.
  always_comb begin
    pc_d          = pc_q + DW'(PC_INC);
    flush_if_id_d = 1'b0;
    flush_id_ex_d = 1'b0;
    if (ex_redirect) begin
      flush_if_id_d = 1'b1;
      flush_id_ex_d = 1'b1;
      if (bp_if.ex_is_jalr) begin
        pc_d = {bp_if.ex_target[DW-1:1], 1'b0};
      end else if (bp_if.ex_taken) begin
        pc_d = bp_if.ex_target;
      end else begin
        pc_d = bp_if.ex_pc + DW'(PC_INC);
      end
    end else if (id_redirect) begin
      pc_d          = bp_if.id_target;
      flush_if_id_d = 1'b1;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  // Saturating performance counters; JALR is neither counted nor trained.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (bp_if.ex_is_branch && (branch_cnt_q != CNT_MAX)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (ex_mispredict && (mispredict_cnt_q != CNT_MAX)) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q             <= RESET_PC;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      pc_q             <= pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign pc_o             = pc_q;
  // Flushes are combinational, so hold them off while reset is asserted.
  assign flush_if_id_o    = rst_ni & flush_if_id_d;
  assign flush_id_ex_o    = rst_ni & flush_id_ex_d;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with hand-computed expectations.
module tb_branch_predict_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic [31:0] pc_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  branch_predict_ctrl_if #(.DW(32)) bp_if ();

  branch_predict_ctrl #(
    .DW          (32),
    .BHT_ENTRIES (16),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .stall_i          (stall_i),
    .pc_o             (pc_o),
    .flush_if_id_o    (flush_if_id_o),
    .flush_id_ex_o    (flush_id_ex_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o),
    .bp_if            (bp_if.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    bp_if.id_is_branch  = 1'b0;
    bp_if.id_pc         = '0;
    bp_if.id_target     = '0;
    bp_if.ex_is_branch  = 1'b0;
    bp_if.ex_is_jalr    = 1'b0;
    bp_if.ex_pc         = '0;
    bp_if.ex_pred_taken = 1'b0;
    bp_if.ex_taken      = 1'b0;
    bp_if.ex_target     = '0;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [31:0] tgt);
    bp_if.id_is_branch = 1'b1;
    bp_if.id_pc        = pc;
    bp_if.id_target    = tgt;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic pred, input logic taken,
                        input logic [31:0] tgt);
    bp_if.ex_is_branch  = 1'b1;
    bp_if.ex_pc         = pc;
    bp_if.ex_pred_taken = pred;
    bp_if.ex_taken      = taken;
    bp_if.ex_target     = tgt;
  endtask

  initial begin
    rst_ni  = 1'b0;
    stall_i = 1'b0;
    clr();
    bp_if.ex_is_jalr = 1'b1;
    #3;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_flush_if", 32'(flush_if_id_o), 32'h0);
    chk("rst_flush_ex", 32'(flush_id_ex_o), 32'h0);
    chk("rst_bcnt", branch_cnt_o, 32'h0);
    chk("rst_mcnt", mispredict_cnt_o, 32'h0);
    bp_if.ex_is_jalr = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("seq_pc0", pc_o, 32'h0);
    tick(); chk("seq_pc4", pc_o, 32'h4);
    tick(); chk("seq_pc8", pc_o, 32'h8);
    tick(); chk("seq_pcC", pc_o, 32'hC);
    chk("seq_flush", 32'({flush_if_id_o, flush_id_ex_o}), 32'h0);

    // Cold branch mispredicted not-taken.
    set_ex(32'h10, 1'b0, 1'b1, 32'h40);
    #1;
    chk("cold_flush", 32'({flush_if_id_o, flush_id_ex_o}), 32'h3);
    tick(); clr();
    chk("cold_pc", pc_o, 32'h40);
    chk("cold_bcnt", branch_cnt_o, 32'd1);
    chk("cold_mcnt", mispredict_cnt_o, 32'd1);

    // Same branch now predicted taken in decode (counter 10).
    set_id(32'h10, 32'h40);
    #1;
    chk("id_pred", 32'(bp_if.id_pred_taken), 32'h1);
    chk("id_flush", 32'({flush_if_id_o, flush_id_ex_o}), 32'h2);
    tick(); clr();
    chk("id_pc", pc_o, 32'h40);
    set_ex(32'h10, 1'b1, 1'b1, 32'h40);
    #1;
    chk("ex_ok_flush", 32'({flush_if_id_o, flush_id_ex_o}), 32'h0);
    tick(); clr();
    chk("ex_ok_pc", pc_o, 32'h44);
    chk("ex_ok_bcnt", branch_cnt_o, 32'd2);
    chk("ex_ok_mcnt", mispredict_cnt_o, 32'd1);

    // EX mispredict beats a stalled decode prediction.
    stall_i = 1'b1;
    set_ex(32'h20, 1'b1, 1'b0, 32'h99);
    set_id(32'h10, 32'h80);
    #1;
    chk("prio_flush", 32'({flush_if_id_o, flush_id_ex_o}), 32'h3);
    tick(); clr();
    chk("prio_pc", pc_o, 32'h24);
    chk("prio_mcnt", mispredict_cnt_o, 32'd2);

    // Stall holds the decode prediction; EX training continues underneath.
    set_id(32'h10, 32'h80);
    set_ex(32'h30, 1'b1, 1'b1, 32'h0);
    #1;
    chk("stl_flush1", 32'({flush_if_id_o, flush_id_ex_o}), 32'h0);
    tick();
    chk("stl_pc1", pc_o, 32'h24);
    bp_if.ex_is_branch = 1'b0;
    #1;
    chk("stl_flush2", 32'({flush_if_id_o, flush_id_ex_o}), 32'h0);
    tick();
    chk("stl_pc2", pc_o, 32'h24);
    stall_i = 1'b0;
    #1;
    chk("stl_rel_flush", 32'({flush_if_id_o, flush_id_ex_o}), 32'h2);
    tick(); clr();
    chk("stl_rel_pc", pc_o, 32'h80);

    // Entry 12 trained to 10 during the stall; same-cycle update reads old value.
    stall_i = 1'b1;
    set_id(32'h30, 32'h200);
    set_ex(32'h30, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rbw_old", 32'(bp_if.id_pred_taken), 32'h1);
    tick();
    bp_if.ex_is_branch = 1'b0;
    #1;
    chk("rbw_new", 32'(bp_if.id_pred_taken), 32'h0);
    chk("rbw_pc", pc_o, 32'h80);
    chk("rbw_bcnt", branch_cnt_o, 32'd5);
    clr();

    // Saturation at 11, then step down to prove no wrap.
    for (int i = 0; i < 5; i++) begin
      set_ex(32'h10, 1'b1, 1'b1, 32'h40);
      tick();
    end
    clr();
    chk("sat_pc", pc_o, 32'h80);
    chk("sat_bcnt", branch_cnt_o, 32'd10);
    set_ex(32'h10, 1'b1, 1'b0, 32'h40);
    tick(); clr();
    chk("sat_mis_pc", pc_o, 32'h14);
    chk("sat_mcnt", mispredict_cnt_o, 32'd3);
    set_id(32'h10, 32'h40);
    #1;
    chk("sat_pred_10", 32'(bp_if.id_pred_taken), 32'h1);
    tick(); clr();
    set_ex(32'h10, 1'b0, 1'b0, 32'h40);
    tick(); clr();
    set_id(32'h10, 32'h40);
    #1;
    chk("sat_pred_01", 32'(bp_if.id_pred_taken), 32'h0);
    tick(); clr();
    set_ex(32'h18, 1'b1, 1'b1, 32'h0);
    tick(); clr();
    set_id(32'h18, 32'h0);
    #1;
    chk("e6_pred", 32'(bp_if.id_pred_taken), 32'h1);
    bp_if.id_is_branch = 1'b0;

    // JALR clears bit 0 and overrides the stall; PC wraps at the top.
    bp_if.ex_is_jalr = 1'b1;
    bp_if.ex_target  = 32'h103;
    #1;
    chk("jalr_flush", 32'({flush_if_id_o, flush_id_ex_o}), 32'h3);
    tick();
    chk("jalr_pc", pc_o, 32'h102);
    bp_if.ex_target = 32'hFFFF_FFFD;
    tick(); clr();
    chk("jalr_hi_pc", pc_o, 32'hFFFF_FFFC);
    stall_i = 1'b0;
    tick(); chk("wrap_pc", pc_o, 32'h0);
    tick(); chk("wrap_pc4", pc_o, 32'h4);
    chk("pre_rst_bcnt", branch_cnt_o, 32'd13);
    chk("pre_rst_mcnt", mispredict_cnt_o, 32'd3);

    // Asynchronous reset between edges.
    #1;
    rst_ni = 1'b0;
    set_id(32'h18, 32'h0);
    #1;
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_bcnt", branch_cnt_o, 32'h0);
    chk("mid_rst_mcnt", mispredict_cnt_o, 32'h0);
    chk("mid_rst_pred", 32'(bp_if.id_pred_taken), 32'h0);
    #2;
    rst_ni = 1'b1;
    clr();
    tick();
    chk("post_rst_pc", pc_o, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
